uart_rx: RTL

Serial receiver directly downstream of `clk_gen`: consumes its 16x oversampling strobe `rx_clk_en`, deserialises LSB-first 8N1 frames (optional parity) from the `rxd` pin, and presents each byte on a valid/ready handshake to the register/FIFO layer. Detects false starts, framing errors, parity errors and overrun.

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_rx_if.sv | 14 +
 rtl/uart_sync.sv | 25 ++
 rtl/uart_rx.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversampling constants
// and a parity helper. The transmitter imports the same package.
package uart_pkg;

  localparam int         OVERSAMPLE  = 16;
  localparam logic [3:0] MID_SAMPLE  = 4'd7;
  localparam logic [3:0] LAST_SAMPLE = 4'd15;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_e;

  // Parity bit over the low nbits of data; odd=1 selects odd parity.
  function automatic logic calc_parity(input logic [8:0] data,
                                       input int         nbits,
                                       input logic       odd);
    logic p;
    p = odd;
    for (int i = 0; i < 9; i++) begin
      if (i < nbits) p = p ^ data[i];
    end
    return p;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Received-byte handshake between uart_rx (master) and the register/FIFO
// layer (slave): rx_data is qualified by rx_valid and taken on rx_ready.
interface uart_rx_if #(
  parameter int DATA_BITS = 8
) ();

  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);

endinterface

// File: rtl/uart_sync.sv
// Parametric N-flop synchroniser for a single asynchronous bit. All flops
// reset to RST_VAL so an idle-high line does not look like a start bit.
module uart_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic arst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments make every stage sample the previous
    // stage's old value; blocking would collapse the chain into one flop.
    if (!arst_n) sync_q <= {STAGES{RST_VAL}};
    else         sync_q <= {sync_q[STAGES-2:0], d};
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 16x oversampling UART receiver, LSB-first frames, valid/ready output.
// Optional parity bit enabled by defining UART_RX_PARITY_EN; without it
// the frame is start + DATA_BITS + stop and parity_err is tied low.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic      clk,
  input  logic      arst_n,
  input  logic      rx_clk_en,
  input  logic      rx_en,
  input  logic      rxd,
`ifdef UART_RX_PARITY_EN
  input  logic      parity_odd,
`endif
  uart_rx_if.master rx_if,
  output logic      busy,
  output logic      frame_err,
  output logic      parity_err,
  output logic      overrun_err
);

  localparam logic [2:0] S_IDLE   = RX_IDLE;
  localparam logic [2:0] S_START  = RX_START;
  localparam logic [2:0] S_DATA   = RX_DATA;
  localparam logic [2:0] S_STOP   = RX_STOP;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] S_PARITY = RX_PARITY;
`endif
  localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

  logic                 rxd_s;
  logic [2:0]           state_q;
  logic [3:0]           os_cnt;
  logic [3:0]           bit_idx;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;

  logic last_tick;
  logic data_tick;
  logic stop_good;
  logic stop_bad;
  logic accept;
  logic load;

  uart_sync #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b1)
  ) u_rxd_sync (
    .clk    (clk),
    .arst_n (arst_n),
    .d      (rxd),
    .q      (rxd_s)
  );

  // Sampling points; gated by rx_en so a disabling edge never samples.
  assign last_tick = rx_en && rx_clk_en && (os_cnt == LAST_SAMPLE);
  assign data_tick = last_tick && (state_q == S_DATA);
  assign stop_good = last_tick && (state_q == S_STOP) && rxd_s;
  assign stop_bad  = last_tick && (state_q == S_STOP) && !rxd_s;

  // A byte being accepted this cycle frees the holding register, so a new
  // byte finishing in the same cycle loads instead of overrunning.
  assign accept = valid_q && rx_if.rx_ready;
  assign load   = stop_good && (!valid_q || accept);

  assign busy           = (state_q != S_IDLE);
  assign rx_if.rx_data  = data_q;
  assign rx_if.rx_valid = valid_q;

  // Frame FSM: tick counter and bit index advance only on rx_clk_en.
  always_ff @(posedge clk) begin
    if (!arst_n || !rx_en) begin
      state_q <= S_IDLE;
      os_cnt  <= '0;
      bit_idx <= '0;
    end else if (rx_clk_en) begin
      os_cnt <= os_cnt + 4'd1;
      case (state_q)
        S_IDLE: begin
          os_cnt <= '0;
          if (!rxd_s) state_q <= S_START;
        end
        S_START: begin
          if (os_cnt == MID_SAMPLE) begin
            os_cnt  <= '0;
            bit_idx <= '0;
            state_q <= rxd_s ? S_IDLE : S_DATA;
          end
        end
        S_DATA: begin
          if (os_cnt == LAST_SAMPLE) begin
            bit_idx <= bit_idx + 4'd1;
            if (bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              state_q <= S_PARITY;
`else
              state_q <= S_STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (os_cnt == LAST_SAMPLE) state_q <= S_STOP;
        end
`endif
        S_STOP: begin
          if (os_cnt == LAST_SAMPLE) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Deserialiser: bits arrive LSB first, so shift in at the MSB.
  always_ff @(posedge clk) begin
    if (!arst_n)        shift_q <= '0;
    else if (data_tick) shift_q <= {rxd_s, shift_q[DATA_BITS-1:1]};
  end

  // Holding register, valid/ready handshake and framing/overrun pulses.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      frame_err   <= stop_bad;
      overrun_err <= stop_good && !load;
      if (load) begin
        data_q  <= shift_q;
        valid_q <= 1'b1;
      end else if (accept) begin
        valid_q <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_bad_q;

  // Compare the received parity bit with the one computed over the byte.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      par_bad_q <= 1'b0;
    end else if (last_tick && (state_q == S_PARITY)) begin
      par_bad_q <= rxd_s != calc_parity(9'(shift_q), DATA_BITS, parity_odd);
    end
  end

  // The parity error is reported alongside the (still delivered) byte.
  always_ff @(posedge clk) begin
    if (!arst_n) parity_err <= 1'b0;
    else         parity_err <= load && par_bad_q;
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule
